// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: FSM state encoding, data width and the baud
// divider calculation. Used by both the transmit and receive paths.
package rs232_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Clock cycles per bit; truncating division so the line runs slightly fast
  // rather than slow when CLK_FREQ is not an exact multiple of BAUD.
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rs232_tx_dat_if.sv
// Byte handshake between user logic and the RS-232 transmitter.
//
// valid/ready: the byte on i_tx_dat is transferred on a rising clock edge
// where i_tx_valid and o_tx_ready are both high. The sender holds valid and
// data stable until that edge; valid seen while ready is low is not queued.
interface rs232_tx_dat_if;
  import rs232_pkg::*;

  logic                 i_tx_valid;
  logic [DATA_BITS-1:0] i_tx_dat;
  logic                 o_tx_ready;

  modport master (output i_tx_valid, output i_tx_dat, input o_tx_ready);
  modport slave  (input i_tx_valid, input i_tx_dat, output o_tx_ready);

endinterface

// File: rtl/rs232_baud_gen.sv
// Baud period counter: counts 0..DIV-1 and flags the last cycle of each bit.
// A synchronous clear holds it at 0 so a new frame starts on a bit boundary.
module rs232_baud_gen #(
  parameter int DIV = 434
) (
  input  logic clk_ref,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int           W    = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Free-running modulo-DIV counter, restarted by clear.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST) && !clear;

endmodule

// File: rtl/rs232_tx_dat.sv
// RS-232 byte transmitter: start bit, 8 data bits LSB first, optional parity,
// STOP_BITS stop bits. Define RS232_TX_PARITY_EN to insert the parity bit
// (even parity, or odd when PARITY_ODD=1). tx_state exposes the FSM.
module rs232_tx_dat
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_ref,
  input  logic                 rst_n,
  rs232_tx_dat_if.slave        tx,
  output logic                 o_tx_pin,
  output logic                 o_tx_busy,
  output logic                 o_tx_done,
  output tx_state_t            tx_state
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  // Elaboration-time guard: the body is empty, a bad setting simply has no
  // legal meaning for the counters below.
  if (PARITY_ODD < 0 || PARITY_ODD > 1 || STOP_BITS < 1 || STOP_BITS > 2 ||
      BAUD_DIV < 2) begin : g_illegal_cfg
  end

  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 bit_end;
  logic                 accept;
`ifdef RS232_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign accept = tx.i_tx_valid && tx.o_tx_ready;

  // Counter is held at zero while idle so the start bit gets a full period.
  rs232_baud_gen #(.DIV(BAUD_DIV)) u_baud (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .clear   (tx_state == TX_IDLE),
    .bit_end (bit_end)
  );

  // Frame sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      tx_state      <= TX_IDLE;
      shift         <= '0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
      o_tx_pin      <= 1'b1;
      tx.o_tx_ready <= 1'b1;
      o_tx_busy     <= 1'b0;
      o_tx_done     <= 1'b0;
`ifdef RS232_TX_PARITY_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      o_tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (accept) begin
            shift         <= tx.i_tx_dat;
`ifdef RS232_TX_PARITY_EN
            parity_bit    <= (^tx.i_tx_dat) ^ 1'(PARITY_ODD);
`endif
            tx_state      <= TX_START;
            o_tx_pin      <= 1'b0;
            tx.o_tx_ready <= 1'b0;
            o_tx_busy     <= 1'b1;
          end
        end
        TX_START: begin
          if (bit_end) begin
            tx_state <= TX_DATA;
            o_tx_pin <= shift[0];
            bit_idx  <= '0;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_BIT) begin
`ifdef RS232_TX_PARITY_EN
              tx_state <= TX_PARITY;
              o_tx_pin <= parity_bit;
`else
              tx_state <= TX_STOP;
              o_tx_pin <= 1'b1;
`endif
              stop_idx <= 1'b0;
            end else begin
              // Present the next bit while shifting, so pin tracks shift[0].
              shift    <= shift >> 1;
              o_tx_pin <= shift[1];
              bit_idx  <= bit_idx + 1'b1;
            end
          end
        end
`ifdef RS232_TX_PARITY_EN
        TX_PARITY: begin
          if (bit_end) begin
            tx_state <= TX_STOP;
            o_tx_pin <= 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (bit_end) begin
            if (stop_idx == LAST_STOP) begin
              tx_state      <= TX_IDLE;
              tx.o_tx_ready <= 1'b1;
              o_tx_busy     <= 1'b0;
              o_tx_done     <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          tx_state      <= TX_IDLE;
          o_tx_pin      <= 1'b1;
          tx.o_tx_ready <= 1'b1;
          o_tx_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx_dat.sv
// Bench for rs232_tx_dat at CLK_FREQ=16, BAUD=1 (16 cycles per bit).
// A line monitor checks every cycle of every frame against a queue of
// expected frames pushed by the byte driver. With RS232_TX_PARITY_EN a second
// instance with PARITY_ODD=1 runs in lockstep for the odd-parity case.
module tb_rs232_tx_dat;
  import rs232_pkg::*;

  localparam int CLK_FREQ  = 16;
  localparam int BAUD      = 1;
  localparam int DIV       = 16;
  localparam int STOP_BITS = 1;
`ifdef RS232_TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME_BITS = 1 + 8 + PAR_BITS + STOP_BITS;
  localparam int FRAME_CYC  = FRAME_BITS * DIV;

  // ---------------- clock / reset ----------------
  logic clk_ref = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk_ref = ~clk_ref;
  always @(posedge clk_ref) cyc <= cyc + 1;

  rs232_tx_dat_if tx_if ();
  logic      o_tx_pin, o_tx_busy, o_tx_done;
  tx_state_t dbg_state;

  rs232_tx_dat #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .STOP_BITS(STOP_BITS), .PARITY_ODD(0)
  ) u_dut (
    .clk_ref  (clk_ref),
    .rst_n    (rst_n),
    .tx       (tx_if),
    .o_tx_pin (o_tx_pin),
    .o_tx_busy(o_tx_busy),
    .o_tx_done(o_tx_done),
    .tx_state (dbg_state)
  );

`ifdef RS232_TX_PARITY_EN
  rs232_tx_dat_if txo_if ();
  logic      odd_pin, odd_busy, odd_done;
  tx_state_t odd_state;
  assign txo_if.i_tx_valid = tx_if.i_tx_valid;
  assign txo_if.i_tx_dat   = tx_if.i_tx_dat;

  rs232_tx_dat #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .STOP_BITS(STOP_BITS), .PARITY_ODD(1)
  ) u_dut_odd (
    .clk_ref  (clk_ref),
    .rst_n    (rst_n),
    .tx       (txo_if),
    .o_tx_pin (odd_pin),
    .o_tx_busy(odd_busy),
    .o_tx_done(odd_done),
    .tx_state (odd_state)
  );
`endif

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [9:0]  exp_q[$];          // {stop, data[7:0], start} per frame
  int          frame_start_q[$];
  int          frame_done_q[$];
  bit          mon_en = 1'b0;
  bit          chk_done_low = 1'b0;
  int          accept_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected line level per bit slot, parity inserted from the data bits.
  function automatic logic [11:0] line_bits(input logic [9:0] l, input bit odd);
    logic [11:0] b;
    b = '1;
    b[8:0] = l[8:0];
`ifdef RS232_TX_PARITY_EN
    b[9] = (^l[8:1]) ^ odd;
`else
    b[9] = l[9] | odd;  // stop bit; odd has no effect without parity
`endif
    return b;
  endfunction

  // Line monitor: one frame per falling start edge, checked cycle by cycle.
  initial begin : monitor
    logic [9:0]  exp_line;
    logic [11:0] exp_bits;
    logic [9:0]  got_line;
    int          bad;
    int          bad_odd;
    int          b;
    forever begin
      @(negedge clk_ref);
      if (chk_done_low) begin
        check("done_pulse_width", 32'(o_tx_done), 32'd0);
        chk_done_low = 1'b0;
      end
      if (mon_en && rst_n && o_tx_pin == 1'b0) begin
        frame_start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: start bit at cycle %0d with no byte pending", cyc);
          exp_line = 10'h3ff;
        end else begin
          exp_line = exp_q.pop_front();
        end
        exp_bits = line_bits(exp_line, 1'b0);
        bad = 0;
        bad_odd = 0;
        got_line = '0;
        for (int off = 0; off < FRAME_CYC; off++) begin
          if (off > 0) @(negedge clk_ref);
          b = off / DIV;
          if (o_tx_pin !== exp_bits[b] || o_tx_busy !== 1'b1 || tx_if.o_tx_ready !== 1'b0)
            bad++;
`ifdef RS232_TX_PARITY_EN
          if (odd_pin !== line_bits(exp_line, 1'b1)[b]) bad_odd++;
`endif
          if (off % DIV == DIV / 2) begin
            if (b <= 8) got_line[b] = o_tx_pin;
            else if (b == FRAME_BITS - 1) got_line[9] = o_tx_pin;
          end
        end
        check("frame_cycles", 32'(bad), 32'd0);
        check("frame_line", 32'(got_line), 32'(exp_line));
`ifdef RS232_TX_PARITY_EN
        check("frame_odd_parity", 32'(bad_odd), 32'd0);
`endif
        @(negedge clk_ref);
        check("done_after_stop", {28'd0, o_tx_done, tx_if.o_tx_ready, o_tx_busy, o_tx_pin},
              32'b1101);
        frame_done_q.push_back(cyc);
        chk_done_low = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] d, input logic [9:0] exp_line, input bit push,
                      input bit keep);
    int n;
    n = 0;
    @(negedge clk_ref);
    while (tx_if.o_tx_ready !== 1'b1 && n < 4000) begin
      @(negedge clk_ref);
      n++;
    end
    check("send_ready", 32'(tx_if.o_tx_ready), 32'd1);
    tx_if.i_tx_valid = 1'b1;
    tx_if.i_tx_dat   = d;
    if (push) exp_q.push_back(exp_line);
    @(posedge clk_ref);
    #1;
    accept_cyc = cyc;
    if (!keep) begin
      tx_if.i_tx_valid = 1'b0;
      tx_if.i_tx_dat   = 8'($urandom);   // must not disturb the frame
    end
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frame_done_q.size() < n && t < 20000) begin
      @(negedge clk_ref);
      t++;
    end
    check("frames_completed", 32'(frame_done_q.size() >= n), 32'd1);
    @(negedge clk_ref);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] dat;
    logic [9:0] exp_line;
  } vec_t;
  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin : main
    int a;
    int nf;
    int done_hi;
    int pin_lo;
    logic [7:0] r;

    vecs[0] = '{8'h00, 10'b1_00000000_0};
    vecs[1] = '{8'hFF, 10'b1_11111111_0};
    vecs[2] = '{8'h07, 10'b1_00000111_0};
    vecs[3] = '{8'hC3, 10'b1_11000011_0};
    vecs[4] = '{8'h96, 10'b1_10010110_0};
    vecs[5] = '{8'h81, 10'b1_10000001_0};

    // Reset state.
    rst_n = 1'b0;
    tx_if.i_tx_valid = 1'b0;
    tx_if.i_tx_dat   = 8'h00;
    repeat (3) @(negedge clk_ref);
    check("rst_pin", 32'(o_tx_pin), 32'd1);
    check("rst_ready", 32'(tx_if.o_tx_ready), 32'd1);
    check("rst_busy", 32'(o_tx_busy), 32'd0);
    check("rst_done", 32'(o_tx_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(TX_IDLE));
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 0x55 with latency: start in the first cycle after the accept edge,
    // done in the cycle right after the last stop bit (161st cycle).
    send(8'h55, 10'b1_01010101_0, 1'b1, 1'b0);
    a = accept_cyc;
    wait_frames(1);
    check("start_latency", 32'(frame_start_q[0] - a), 32'd0);
    check("done_latency", 32'(frame_done_q[0] - a), 32'(FRAME_CYC));

    // Back-to-back with valid held high: one idle cycle between frames.
    send(8'hA5, 10'b1_10100101_0, 1'b1, 1'b1);
    send(8'h3C, 10'b1_00111100_0, 1'b1, 1'b0);
    wait_frames(3);
    check("b2b_gap", 32'(frame_start_q[2] - frame_done_q[1]), 32'd1);

    // Valid pulsed mid-frame is ignored and not queued.
    send(8'h5A, 10'b1_01011010_0, 1'b1, 1'b0);
    repeat (80) @(negedge clk_ref);
    tx_if.i_tx_valid = 1'b1;
    tx_if.i_tx_dat   = 8'hFF;
    @(negedge clk_ref);
    tx_if.i_tx_valid = 1'b0;
    wait_frames(4);
    repeat (FRAME_CYC + 20) @(negedge clk_ref);
    check("no_extra_frame", 32'(frame_start_q.size()), 32'd4);

    // Table vectors with short random idle gaps.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_ref);
      send(vecs[i].dat, vecs[i].exp_line, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom_range(0, 255));
      send(r, {1'b1, r, 1'b0}, 1'b1, 1'b0);
    end
    wait_frames(14);

    // Reset during data bit 3 of 0xF0 (bit value 0): pin returns high at once.
    mon_en = 1'b0;
    send(8'hF0, 10'b1_11110000_0, 1'b0, 1'b0);
    repeat (73) @(negedge clk_ref);
    check("pre_reset_bit3", 32'(o_tx_pin), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_pin", 32'(o_tx_pin), 32'd1);
    check("async_rst_busy", 32'(o_tx_busy), 32'd0);
    check("async_rst_ready", 32'(tx_if.o_tx_ready), 32'd1);
    check("async_rst_done", 32'(o_tx_done), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(TX_IDLE));
    repeat (3) @(negedge clk_ref);
    rst_n = 1'b1;
    done_hi = 0;
    pin_lo  = 0;
    for (int i = 0; i < FRAME_CYC + 4; i++) begin
      @(negedge clk_ref);
      if (o_tx_done) done_hi++;
      if (!o_tx_pin) pin_lo++;
    end
    check("abort_no_done", 32'(done_hi), 32'd0);
    check("abort_line_idle", 32'(pin_lo), 32'd0);

    mon_en = 1'b1;
    nf = frame_done_q.size();
    send(8'h81, 10'b1_10000001_0, 1'b1, 1'b0);
    wait_frames(nf + 1);

    repeat (DIV) @(negedge clk_ref);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin : watchdog
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rs232_tx_dat.md
# rs232_tx_dat

Byte-wide RS-232 transmitter: accepts a byte through a valid/ready handshake, serialises it onto `o_tx_pin` as start bit, 8 data bits LSB first, optional parity bit and stop bit(s), each bit held one baud period. It is the transmit-side counterpart of the UART receive path and sits between user logic and the board TX pin, sharing `clk_ref`.

## Interface
- `CLK_FREQ`, 50_000_000: `clk_ref` frequency in Hz.
- `BAUD`, 115200: line rate in bit/s. `BAUD_DIV = CLK_FREQ/BAUD`, truncated (434 at defaults), must be ≥ 2.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `PARITY_ODD`, 0: 0 = even, 1 = odd. Used only with `RS232_TX_PARITY_EN`.
- `clk_ref` input, 1 bit: system clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `i_tx_valid` input, 1 bit: byte on `i_tx_dat` is offered.
- `i_tx_dat` input, 8 bits: byte to send.
- `o_tx_ready` output, 1 bit: transmitter can accept a byte.
- `o_tx_pin` output, 1 bit: serial line, idle high.
- `o_tx_busy` output, 1 bit: a frame is on the line.
- `o_tx_done` output, 1 bit: one-cycle pulse after the last stop bit completes.

## Operation
- FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE: `o_tx_pin`=1, `o_tx_ready`=1, `o_tx_busy`=0. When `i_tx_valid && o_tx_ready` is sampled, the byte is latched into the shift register and the FSM goes to START. Later changes on `i_tx_dat` have no effect on the frame.
- Baud counter: 0..BAUD_DIV-1, cleared on acceptance. A bit ends when the counter reaches BAUD_DIV-1.
- START: pin 0 for one bit period.
- DATA: bit index 0..7, pin = `shift[0]`, shift right at each bit end. After index 7 the FSM goes to PARITY if compiled in, otherwise to STOP.
- STOP: pin 1 for STOP_BITS bit periods. Then IDLE, with `o_tx_done` pulsed for one cycle.
- `i_tx_valid` while not ready: ignored, not queued. The sender holds valid until ready.
- Reset at any point, including mid-frame: immediately `o_tx_pin`=1, `o_tx_busy`=0, `o_tx_done`=0, `o_tx_ready`=1, FSM in IDLE, counters 0. No done pulse is produced for the aborted frame.

## Timing
- Reset values: `o_tx_pin`=1, `o_tx_ready`=1, `o_tx_busy`=0, `o_tx_done`=0.
- All outputs are registered.
- Acceptance at edge N: from N+1, pin=0, busy=1, ready=0.
- Each bit lasts exactly BAUD_DIV cycles.
- Frame length: (10 + STOP_BITS − 1) × BAUD_DIV cycles, plus BAUD_DIV cycles with parity.
- `o_tx_done` and `o_tx_ready` both go high in the first cycle after the last stop bit. A byte accepted in that cycle starts its start bit on the next cycle. This gives exactly one idle-high cycle between back-to-back frames.

## Configuration
- `RS232_TX_PARITY_EN` defined: a PARITY state follows DATA. Pin = XOR of the 8 data bits, XOR `PARITY_ODD`, held one bit period. Frame grows by one bit.
- Macro not defined: no PARITY state, no parity logic, and `PARITY_ODD` is unused.

## Structure
- Shared package `rs232_pkg`: FSM state enum (`TX_IDLE`, `TX_START`, `TX_DATA`, `TX_PARITY`, `TX_STOP`), `DATA_BITS`=8, and the function computing `BAUD_DIV` from `CLK_FREQ`/`BAUD`. The receive side reuses the package.
- One sub-module, `rs232_baud_gen`: baud counter with a synchronous clear and a one-cycle `bit_end` output. It is shared with the receive path.

## Test plan
- Reset check (CLK_FREQ=16, BAUD=1, BAUD_DIV=16): hold `rst_n` low → pin=1, ready=1, busy=0, done=0.
- Send 0x55 → line reads 0, then 1,0,1,0,1,0,1,0, then 1, each bit 16 cycles. Done pulses once at cycle 161 after acceptance.
- Back-to-back 0xA5 then 0x3C, valid held high → second start bit begins exactly one cycle after the first frame's done. Data bits decode LSB first as 0xA5 then 0x3C.
- Valid pulsed with 0xFF while busy mid-frame → ignored. Frame content is unchanged and no extra frame follows.
- `rst_n` asserted during data bit 3 → pin=1 in the same cycle, with no done pulse. Next byte 0x81 then transmits correctly.
- With `RS232_TX_PARITY_EN`, PARITY_ODD=0, send 0x07 → parity bit 1, frame 11 bits. With PARITY_ODD=1, parity bit 0.
